frame_update_sequencer: RTL

//  Per-frame scheduler for the entity update units (player, sword, enemies).
//  On every FRAME_DIV-th frame_tick it snapshots controller input once.
//  It then issues one-cycle trigger pulses to each enabled entity in index order.

---
 rtl/frame_update_sequencer_pkg.sv | 22 ++
 rtl/frame_update_sequencer_divider.sv | 30 +++
 rtl/frame_update_sequencer.sv | 127 ++++++++++++
 3 files changed

// File: rtl/frame_update_sequencer_pkg.sv
// Shared definitions for the per-frame entity update sequencer.
// FSM state encoding and controller bit positions.
package frame_update_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LATCH    = 3'd1,
    S_DISPATCH = 3'd2,
    S_WAIT     = 3'd3,
    S_NEXT     = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  localparam int ATTACK_BIT = 9;
  localparam int DIR_R_BIT  = 8;
  localparam int DIR_L_BIT  = 7;
  localparam int DIR_D_BIT  = 6;
  localparam int DIR_U_BIT  = 5;
  localparam int SWORD_BIT  = 4;
  localparam int IN_W       = ATTACK_BIT + 1;

endpackage

// File: rtl/frame_update_sequencer_divider.sv
// Frame-tick prescaler: emits round_start on every FRAME_DIV-th
// accepted tick, so the sequencer FSM carries no prescale logic.
module frame_divider
  import frame_update_sequencer_pkg::*;
#(
  parameter int FRAME_DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  output logic round_start
);

  localparam logic [3:0] LAST = 4'(FRAME_DIV - 1);

  logic [3:0] div_cnt;

  assign round_start = tick && (div_cnt == LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      div_cnt <= '0;
    end else if (round_start) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= div_cnt + 4'd1;
    end
  end

endmodule

// File: rtl/frame_update_sequencer.sv
// Per-frame scheduler: snapshots controller input, then triggers each
// enabled entity in index order, waiting on done or a timeout.
module frame_update_sequencer
  import frame_update_sequencer_pkg::*;
#(
  parameter int NUM_ENT   = 4,
  parameter int FRAME_DIV = 1,
  parameter int TIMEOUT   = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic [IN_W-1:0]    input_data,
  input  logic [NUM_ENT-1:0] ent_enable,
  input  logic [NUM_ENT-1:0] ent_done,
  input  logic               err_clear,
  output logic [NUM_ENT-1:0] ent_trigger,
  output logic [IN_W-1:0]    input_snapshot,
  output logic               busy,
  output logic               frame_done,
  output logic               overrun,
  output logic [NUM_ENT-1:0] timeout_err
);

  localparam int IW = (NUM_ENT > 1) ? $clog2(NUM_ENT) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_ENT - 1);
  localparam logic [7:0] TMAX = 8'(TIMEOUT);

  state_t state, state_n;
  logic [IW-1:0] idx, idx_n;
  logic [7:0] timer;
  logic [NUM_ENT-1:0] trig_q, trig_n;
  logic [NUM_ENT-1:0] to_set;
  logic idle, round_start, wait_expired;

  assign idle = (state == S_IDLE);

  frame_divider #(
    .FRAME_DIV(FRAME_DIV)
  ) u_div (
    .clk        (clk),
    .reset      (reset),
    .tick       (frame_tick && idle),
    .round_start(round_start)
  );

  assign wait_expired = (state == S_WAIT) && !ent_done[idx]
                     && (timer == TMAX);

  always_comb begin
    state_n = state;
    idx_n   = idx;
    unique case (state)
      S_IDLE: begin
        if (round_start) state_n = S_LATCH;
      end
      S_LATCH: begin
        idx_n   = '0;
        state_n = S_DISPATCH;
      end
      S_DISPATCH: begin
        state_n = (|trig_q) ? S_WAIT : S_NEXT;
      end
      S_WAIT: begin
        if (ent_done[idx] || timer == TMAX) state_n = S_NEXT;
      end
      S_NEXT: begin
        if (idx == LAST_IDX) begin
          state_n = S_DONE;
        end else begin
          idx_n   = idx + 1'b1;
          state_n = S_DISPATCH;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // Trigger is registered so the pulse depends on no same-cycle input.
  always_comb begin
    trig_n = '0;
    if (state_n == S_DISPATCH && ent_enable[idx_n]) trig_n[idx_n] = 1'b1;
  end

  always_comb begin
    to_set = '0;
    if (wait_expired) to_set[idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= S_IDLE;
      idx            <= '0;
      timer          <= '0;
      trig_q         <= '0;
      input_snapshot <= '0;
      overrun        <= 1'b0;
      timeout_err    <= '0;
    end else begin
      state  <= state_n;
      idx    <= idx_n;
      trig_q <= trig_n;
      if (state == S_DISPATCH) begin
        timer <= '0;
      end else if (state == S_WAIT && !ent_done[idx] && timer != TMAX) begin
        timer <= timer + 8'd1;
      end
      if (state == S_LATCH) input_snapshot <= input_data;
      if (frame_tick && !idle) begin
        overrun <= 1'b1;
      end else if (err_clear) begin
        overrun <= 1'b0;
      end
      timeout_err <= (err_clear ? '0 : timeout_err) | to_set;
    end
  end

  assign ent_trigger = trig_q;
  assign busy        = !idle;
  assign frame_done  = (state == S_DONE);

endmodule
